// File: rtl/spi_bridge_pkg.sv
// Shared types for the SPI-to-memory bridge: word type codes, FSM states and
// the 20-bit command buffer entry.
package spi_bridge_pkg;

    localparam logic [1:0] DA_NONE  = 2'b00;
    localparam logic [1:0] DA_ADDR  = 2'b01;
    localparam logic [1:0] DA_WDATA = 2'b10;
    localparam logic [1:0] DA_RCMD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic [1:0]  da_type;
        logic        doa;
        logic        rw;
        logic [15:0] data;
    } fifo_entry_t;

    function automatic logic [15:0] addr_step(input logic [15:0] addr, input logic inc);
        return addr + {15'd0, inc};
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Single-clock command buffer. A push into a full buffer is only accepted when
// a pop frees a slot in the same cycle.
module spi_cmd_fifo
    import spi_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [19:0] wdata,
    input  logic        pop,
    output logic [19:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [19:0] mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        push_ok_s;
    logic        pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Entry storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// Bridges address/data words from the SPI front end onto a request/grant
// memory port with at most one transaction in flight.
module spi_mem_bridge
    import spi_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AUTO_INC   = 1
) (
    input  logic        clkOut,
    input  logic        reset_network,
    input  logic [15:0] DA_in,
    input  logic [1:0]  DA_valid_in,
    input  logic        DoA_in,
    input  logic        rw_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] data_out,
    output logic        data_out_valid,
    output logic        busy,
    output logic        overflow
);

    localparam logic INC_BIT = (AUTO_INC != 0) ? 1'b1 : 1'b0;

    bridge_state_e state_r, state_nxt_s;
    fifo_entry_t   push_entry_s, head_s;
    logic          push_s, pop_s, fifo_full_s, fifo_empty_s;
    logic          overflow_r;
    logic [15:0]   addr_reg_r, addr_reg_nxt_s;
    logic          mem_req_r, mem_req_nxt_s;
    logic          mem_we_r, mem_we_nxt_s;
    logic          mem_sel_r, mem_sel_nxt_s;
    logic [15:0]   mem_addr_r, mem_addr_nxt_s;
    logic [15:0]   mem_wdata_r, mem_wdata_nxt_s;
    logic [15:0]   data_out_r, data_out_nxt_s;
    logic          dov_r, dov_nxt_s;

    assign push_s       = (DA_valid_in != DA_NONE);
    assign push_entry_s = {DA_valid_in, DoA_in, rw_in, DA_in};
    assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;

    spi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clkOut),
        .rst   (reset_network),
        .push  (push_s),
        .wdata (push_entry_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clkOut) begin
        if (reset_network) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; gnt and rvalid only matter in their own states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    case (head_s.da_type)
                        DA_WDATA: state_nxt_s = head_s.rw ? ST_ISSUE : ST_IDLE;
                        DA_RCMD:  state_nxt_s = ST_ISSUE;
                        default:  state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    state_nxt_s = mem_we_r ? ST_IDLE : ST_RD_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered memory-port and read-back outputs.
    always_comb begin
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_sel_nxt_s   = mem_sel_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        addr_reg_nxt_s  = addr_reg_r;
        data_out_nxt_s  = data_out_r;
        dov_nxt_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    case (head_s.da_type)
                        DA_ADDR: addr_reg_nxt_s = head_s.data;
                        DA_WDATA: begin
                            if (head_s.rw) begin
                                mem_req_nxt_s   = 1'b1;
                                mem_we_nxt_s    = 1'b1;
                                mem_sel_nxt_s   = head_s.doa;
                                mem_addr_nxt_s  = addr_reg_r;
                                mem_wdata_nxt_s = head_s.data;
                            end else begin
                                mem_req_nxt_s   = 1'b0;
                            end
                        end
                        DA_RCMD: begin
                            mem_req_nxt_s  = 1'b1;
                            mem_we_nxt_s   = 1'b0;
                            mem_sel_nxt_s  = head_s.doa;
                            mem_addr_nxt_s = head_s.data;
                        end
                        default: mem_req_nxt_s = 1'b0;
                    endcase
                end else begin
                    mem_req_nxt_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                // mem_addr already holds the write address or the read address.
                if (mem_gnt) begin
                    mem_req_nxt_s  = 1'b0;
                    addr_reg_nxt_s = addr_step(mem_addr_r, INC_BIT);
                end else begin
                    mem_req_nxt_s  = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    data_out_nxt_s = mem_rdata;
                    dov_nxt_s      = 1'b1;
                end else begin
                    dov_nxt_s      = 1'b0;
                end
            end
            default: mem_req_nxt_s = 1'b0;
        endcase
    end

    // Output and address registers, plus the sticky overflow flag.
    always_ff @(posedge clkOut) begin
        if (reset_network) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_sel_r   <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
            addr_reg_r  <= 16'h0000;
            data_out_r  <= 16'h0000;
            dov_r       <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_sel_r   <= mem_sel_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            addr_reg_r  <= addr_reg_nxt_s;
            data_out_r  <= data_out_nxt_s;
            dov_r       <= dov_nxt_s;
            if (push_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_sel        = mem_sel_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign data_out       = data_out_r;
    assign data_out_valid = dov_r;
    assign overflow       = overflow_r;
    assign busy           = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: expected memory requests and read-back
// words are queued as stimulus is driven and popped when the DUT produces them.
module tb_spi_mem_bridge;
    import spi_bridge_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic        clkOut;
    logic        reset_network;
    logic [15:0] DA_in;
    logic [1:0]  DA_valid_in;
    logic        DoA_in;
    logic        rw_in;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        busy;
    logic        overflow;

    typedef struct {
        logic        we;
        logic        sel;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] model_addr;
    int          total;
    int          bad;

    spi_mem_bridge #(.FIFO_DEPTH(FIFO_DEPTH), .AUTO_INC(1)) dut (
        .clkOut         (clkOut),
        .reset_network  (reset_network),
        .DA_in          (DA_in),
        .DA_valid_in    (DA_valid_in),
        .DoA_in         (DoA_in),
        .rw_in          (rw_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_sel        (mem_sel),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .overflow       (overflow)
    );

    initial clkOut = 1'b0;
    always #5 clkOut = ~clkOut;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [1:0] t, input logic doa, input logic rw, input logic [15:0] d);
        DA_valid_in = t;
        DoA_in      = doa;
        rw_in       = rw;
        DA_in       = d;
        @(posedge clkOut); #1;
        DA_valid_in = 2'b00;
    endtask

    task automatic set_addr(input logic [15:0] a);
        model_addr = a;
        push_word(DA_ADDR, 1'b0, 1'b0, a);
    endtask

    task automatic wr(input logic doa, input logic [15:0] d, input bit exec);
        req_t e;
        if (exec) begin
            e.we = 1'b1; e.sel = doa; e.addr = model_addr; e.wdata = d;
            req_q.push_back(e);
            model_addr = model_addr + 16'd1;
        end
        push_word(DA_WDATA, doa, 1'b1, d);
    endtask

    task automatic rd(input logic doa, input logic [15:0] a);
        req_t e;
        e.we = 1'b0; e.sel = doa; e.addr = a; e.wdata = 16'h0000;
        req_q.push_back(e);
        model_addr = a + 16'd1;
        push_word(DA_RCMD, doa, 1'b0, a);
    endtask

    // Wait for a request, compare it with the scoreboard, hold gnt low for
    // 'delay' cycles checking stability, then grant for one cycle.
    task automatic serve(input int delay, input string tag);
        int   n;
        req_t e;
        n = 0;
        @(negedge clkOut);
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clkOut);
            n++;
        end
        check1({tag, "_req"}, mem_req, 1'b1);
        check1({tag, "_sb"}, req_q.size() != 0, 1'b1);
        if (req_q.size() != 0) begin
            e = req_q.pop_front();
            check1({tag, "_we"}, mem_we, e.we);
            check1({tag, "_sel"}, mem_sel, e.sel);
            check16({tag, "_addr"}, mem_addr, e.addr);
            if (e.we) check16({tag, "_wdata"}, mem_wdata, e.wdata);
            for (int i = 0; i < delay; i++) begin
                @(negedge clkOut);
                check1({tag, "_hold_req"}, mem_req, 1'b1);
                check16({tag, "_hold_addr"}, mem_addr, e.addr);
                if (e.we) check16({tag, "_hold_wdata"}, mem_wdata, e.wdata);
            end
        end
        mem_gnt = 1'b1;
        @(posedge clkOut); #1;
        mem_gnt = 1'b0;
    endtask

    task automatic rvalid_resp(input int lat, input logic [15:0] d);
        repeat (lat) @(posedge clkOut);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(posedge clkOut); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
    endtask

    task automatic expect_rdata(input string tag);
        int          n;
        logic [15:0] e;
        n = 0;
        @(negedge clkOut);
        while (data_out_valid !== 1'b1 && n < 20) begin
            @(negedge clkOut);
            n++;
        end
        check1({tag, "_dov"}, data_out_valid, 1'b1);
        check1({tag, "_sb"}, rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            check16({tag, "_data"}, data_out, e);
            @(negedge clkOut);
            check1({tag, "_pulse"}, data_out_valid, 1'b0);
            check16({tag, "_hold"}, data_out, e);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        model_addr    = 16'h0000;
        reset_network = 1'b1;
        DA_in         = 16'h0000;
        DA_valid_in   = 2'b00;
        DoA_in        = 1'b0;
        rw_in         = 1'b0;
        mem_gnt       = 1'b0;
        mem_rdata     = 16'h0000;
        mem_rvalid    = 1'b0;
        repeat (2) @(posedge clkOut);
        #1;
        reset_network = 1'b0;

        // Reset values
        @(negedge clkOut);
        check1("rst_req", mem_req, 1'b0);
        check1("rst_we", mem_we, 1'b0);
        check1("rst_sel", mem_sel, 1'b0);
        check16("rst_addr", mem_addr, 16'h0000);
        check16("rst_wdata", mem_wdata, 16'h0000);
        check16("rst_dout", data_out, 16'h0000);
        check1("rst_dov", data_out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ovf", overflow, 1'b0);
        @(posedge clkOut); #1;

        // Address then write, granted after 3 cycles; follow-up write shows 0x0101
        set_addr(16'h0100);
        wr(1'b1, 16'hBEEF, 1'b1);
        serve(3, "t1");
        @(negedge clkOut);
        check1("t1_req_drop", mem_req, 1'b0);
        wr(1'b1, 16'h5A5A, 1'b1);
        serve(0, "t1_inc");

        // Read with immediate grant and rvalid five cycles later
        rd(1'b0, 16'h0040);
        rd_q.push_back(16'h1234);
        serve(0, "t2");
        @(negedge clkOut);
        check1("t2_rdwait_req", mem_req, 1'b0);
        check1("t2_rdwait_busy", busy, 1'b1);
        rvalid_resp(4, 16'h1234);
        expect_rdata("t2");
        wr(1'b0, 16'h7777, 1'b1);
        serve(0, "t2_inc");

        // Address wrap
        set_addr(16'hFFFF);
        wr(1'b1, 16'h1111, 1'b1);
        wr(1'b0, 16'h2222, 1'b1);
        serve(0, "wrap0");
        serve(0, "wrap1");

        // Write word with rw=0 is discarded
        push_word(DA_WDATA, 1'b1, 1'b0, 16'h9999);
        for (int i = 0; i < 6; i++) begin
            @(negedge clkOut);
            check1("t5_no_req", mem_req, 1'b0);
        end
        check1("t5_busy", busy, 1'b0);
        @(posedge clkOut); #1;
        wr(1'b1, 16'hABCD, 1'b1);
        serve(0, "t5_post");

        // Overflow with grant held low
        set_addr(16'h0200);
        repeat (3) @(posedge clkOut);
        #1;
        for (int i = 0; i < 6; i++) begin
            wr(1'b1, 16'hC000 + 16'(i), i < FIFO_DEPTH + 1);
            if (i == 4) check1("ovf_before", overflow, 1'b0);
        end
        check1("ovf_set", overflow, 1'b1);
        check1("ovf_busy", busy, 1'b1);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            serve(0, "ovf");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clkOut);
            check1("ovf_extra_req", mem_req, 1'b0);
        end
        check1("ovf_sticky", overflow, 1'b1);
        check1("ovf_sb_empty", req_q.size() == 0, 1'b1);

        // Reset while waiting for read data, then a late rvalid
        rd(1'b1, 16'h0300);
        serve(0, "t6");
        @(negedge clkOut);
        check1("t6_rdwait_busy", busy, 1'b1);
        reset_network = 1'b1;
        @(posedge clkOut); #1;
        reset_network = 1'b0;
        model_addr    = 16'h0000;
        mem_rvalid    = 1'b1;
        mem_rdata     = 16'hDEAD;
        @(posedge clkOut); #1;
        mem_rvalid    = 1'b0;
        mem_rdata     = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clkOut);
            check1("t6_no_dov", data_out_valid, 1'b0);
        end
        check1("t6_req", mem_req, 1'b0);
        check1("t6_we", mem_we, 1'b0);
        check1("t6_sel", mem_sel, 1'b0);
        check16("t6_addr", mem_addr, 16'h0000);
        check16("t6_wdata", mem_wdata, 16'h0000);
        check16("t6_dout", data_out, 16'h0000);
        check1("t6_busy", busy, 1'b0);
        check1("t6_ovf", overflow, 1'b0);
        @(posedge clkOut); #1;
        wr(1'b0, 16'h4242, 1'b1);
        serve(0, "t6_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
